// File: rtl/serdes_range_tx.sv
// Transmit framer for the range-data SerDes lane: buffers one burst of 13-bit samples,
// then emits a 64-bit sync header (four 16-bit words) followed by the buffered payload.
module serdes_range_tx #(
    parameter logic [63:0] P_TX_SYNC    = 64'hf1ba_84ff_5a5a_6699,
    parameter int unsigned P_ADDR_W     = 10,
    parameter int unsigned P_GAP_CYCLES = 8
) (
    input  logic        I_serdes_tx_clk,
    input  logic        I_sys_rst_n,
    input  logic [12:0] I_range_data,
    input  logic        I_range_en,
    output logic [15:0] O_serdes_tx_data,
    output logic        O_serdes_tx_en,
    output logic        O_busy,
    output logic        O_drop
);

    localparam int unsigned DEPTH = 2 ** P_ADDR_W;
    localparam logic [P_ADDR_W:0] DEPTH_C = {1'b1, {P_ADDR_W{1'b0}}};

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StCollect = 3'd1;
    localparam logic [2:0] StSync    = 3'd2;
    localparam logic [2:0] StPayload = 3'd3;
    localparam logic [2:0] StGap     = 3'd4;

    logic [2:0]          state_q, state_d;
    logic [P_ADDR_W:0]   count_q, count_d;
    logic [P_ADDR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [1:0]          sync_idx_q, sync_idx_d;
    logic [7:0]          gap_cnt_q, gap_cnt_d;
    logic                drop_latch_q, drop_latch_d;
    logic [15:0]         data_d;
    logic                en_d, busy_d, drop_d;
    logic                wr_en;
    logic [P_ADDR_W-1:0] wr_addr;
    logic [12:0]         rd_data_q;
    logic [12:0]         mem [DEPTH];

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        rd_ptr_d     = rd_ptr_q;
        sync_idx_d   = sync_idx_q;
        gap_cnt_d    = gap_cnt_q;
        drop_latch_d = drop_latch_q;
        data_d       = 16'h0000;
        en_d         = 1'b0;
        drop_d       = 1'b0;
        wr_en        = 1'b0;
        wr_addr      = count_q[P_ADDR_W-1:0];

        if (!I_range_en) begin
            drop_latch_d = 1'b0;
        end

        case (state_q)
            StIdle: begin
                if (I_range_en) begin
                    if (drop_latch_q) begin
                        drop_d = 1'b1;
                    end else begin
                        wr_en   = 1'b1;
                        wr_addr = '0;
                        count_d = {{P_ADDR_W{1'b0}}, 1'b1};
                        state_d = StCollect;
                    end
                end
            end
            StCollect: begin
                if (I_range_en) begin
                    if (count_q == DEPTH_C) begin
                        drop_d = 1'b1;
                    end else begin
                        wr_en   = 1'b1;
                        count_d = count_q + 1'b1;
                    end
                end else begin
                    state_d    = StSync;
                    data_d     = P_TX_SYNC[63:48];
                    en_d       = 1'b1;
                    sync_idx_d = 2'd1;
                    rd_ptr_d   = '0;
                end
            end
            StSync: begin
                en_d       = 1'b1;
                sync_idx_d = sync_idx_q + 2'd1;
                case (sync_idx_q)
                    2'd1:    data_d = P_TX_SYNC[47:32];
                    2'd2:    data_d = P_TX_SYNC[31:16];
                    default: data_d = P_TX_SYNC[15:0];
                endcase
                // Address 0 has been prefetched; step ahead so the next read is word 1.
                if (sync_idx_q == 2'd3) begin
                    state_d  = StPayload;
                    rd_ptr_d = rd_ptr_q + 1'b1;
                end
            end
            StPayload: begin
                data_d   = {3'b000, rd_data_q};
                en_d     = 1'b1;
                rd_ptr_d = rd_ptr_q + 1'b1;
                // rd_ptr runs one ahead of the word being emitted.
                if (rd_ptr_q == count_q) begin
                    state_d   = StGap;
                    gap_cnt_d = '0;
                end
            end
            StGap: begin
                if (gap_cnt_q == 8'(P_GAP_CYCLES)) begin
                    state_d = StIdle;
                end else begin
                    gap_cnt_d = gap_cnt_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (I_range_en && (state_q == StSync || state_q == StPayload || state_q == StGap)) begin
            drop_d       = 1'b1;
            drop_latch_d = 1'b1;
        end

        busy_d = (state_d == StSync) || (state_d == StPayload) || (state_d == StGap);
    end

    always_ff @(posedge I_serdes_tx_clk or negedge I_sys_rst_n) begin
        if (!I_sys_rst_n) begin
            state_q          <= StIdle;
            count_q          <= '0;
            rd_ptr_q         <= '0;
            sync_idx_q       <= '0;
            gap_cnt_q        <= '0;
            drop_latch_q     <= 1'b0;
            O_serdes_tx_data <= 16'h0000;
            O_serdes_tx_en   <= 1'b0;
            O_busy           <= 1'b0;
            O_drop           <= 1'b0;
        end else begin
            state_q          <= state_d;
            count_q          <= count_d;
            rd_ptr_q         <= rd_ptr_d;
            sync_idx_q       <= sync_idx_d;
            gap_cnt_q        <= gap_cnt_d;
            drop_latch_q     <= drop_latch_d;
            O_serdes_tx_data <= data_d;
            O_serdes_tx_en   <= en_d;
            O_busy           <= busy_d;
            O_drop           <= drop_d;
        end
    end

    always_ff @(posedge I_serdes_tx_clk) begin
        if (wr_en) begin
            mem[wr_addr] <= I_range_data;
        end
        rd_data_q <= mem[rd_ptr_q[P_ADDR_W-1:0]];
    end

endmodule

// File: tb/tb_serdes_range_tx.sv
// Scoreboard bench for serdes_range_tx: stimulus pushes expected lane words, a negedge
// monitor pops and compares every word presented with tx_en high.
module tb_serdes_range_tx;

    localparam logic [63:0] SYNC = 64'hf1ba_84ff_5a5a_6699;

    logic        clk;
    logic        rst_n;
    logic [12:0] rdata;
    logic        ren;
    logic [15:0] tx_data;
    logic        tx_en;
    logic        busy;
    logic        drop;

    logic [15:0] exp_q[$];
    logic [12:0] stim[$];
    int          checks = 0;
    int          failures = 0;
    int          n_en = 0;
    int          n_drop = 0;
    int          exp_drops = 0;

    serdes_range_tx dut (
        .I_serdes_tx_clk (clk),
        .I_sys_rst_n     (rst_n),
        .I_range_data    (rdata),
        .I_range_en      (ren),
        .O_serdes_tx_data(tx_data),
        .O_serdes_tx_en  (tx_en),
        .O_busy          (busy),
        .O_drop          (drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every lane word is checked against the scoreboard queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (tx_en) begin
                n_en++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_word: got %h expected none", tx_data);
                end else begin
                    logic [15:0] e;
                    e = exp_q.pop_front();
                    if (tx_data !== e) begin
                        failures++;
                        $display("FAIL lane_word: got %h expected %h", tx_data, e);
                    end
                end
            end else begin
                checks++;
                if (tx_data !== 16'h0000) begin
                    failures++;
                    $display("FAIL idle_data: got %h expected 0000", tx_data);
                end
            end
            if (drop) n_drop++;
        end
    end

    task automatic push_frame(input int n);
        logic [63:0] s;
        int          kept;
        s = SYNC;
        for (int i = 0; i < 4; i++) exp_q.push_back(s[63-16*i -: 16]);
        kept = (n > 1024) ? 1024 : n;
        for (int i = 0; i < kept; i++) exp_q.push_back({3'b000, stim[i]});
        if (n > 1024) exp_drops += n - 1024;
    endtask

    task automatic drive_burst();
        push_frame(stim.size());
        @(posedge clk);
        #1;
        for (int i = 0; i < stim.size(); i++) begin
            rdata = stim[i];
            ren   = 1'b1;
            @(posedge clk);
            #1;
        end
        ren   = 1'b0;
        rdata = '0;
    endtask

    task automatic wait_idle(input int budget);
        int c = 0;
        while ((exp_q.size() != 0 || busy) && c < budget) begin
            @(negedge clk);
            c++;
        end
        check("frame_done_in_budget", 32'(c < budget), 32'd1);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, d0, busy_c, cnt, post;
        rst_n = 1'b1;
        rdata = '0;
        ren   = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("rst_data", 32'(tx_data), 32'h0);
        check("rst_en", 32'(tx_en), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_drop", 32'(drop), 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // 3-sample burst: latency, frame length and busy span.
        stim = '{13'h0001, 13'h1fff, 13'h0aaa};
        e0 = n_en;
        drive_burst();
        @(negedge clk);
        check("latency_pre", 32'(tx_en), 32'h0);
        @(negedge clk);
        check("latency_first", 32'(tx_en), 32'h1);
        busy_c = busy ? 1 : 0;
        repeat (30) begin
            @(negedge clk);
            if (busy) busy_c++;
        end
        check("busy_cycles_3", 32'(busy_c), 32'd15);
        wait_idle(50);
        check("en_cycles_3", 32'(n_en - e0), 32'd7);

        // One-sample burst.
        stim = '{13'h1234};
        e0 = n_en;
        drive_burst();
        wait_idle(50);
        check("en_cycles_1", 32'(n_en - e0), 32'd5);

        // Overflow: 1030 samples into a 1024-deep buffer.
        stim.delete();
        for (int i = 0; i < 1030; i++) stim.push_back(13'(i));
        e0 = n_en;
        d0 = n_drop;
        drive_burst();
        wait_idle(1200);
        check("en_cycles_overflow", 32'(n_en - e0), 32'd1028);
        check("drops_overflow", 32'(n_drop - d0), 32'd6);

        // Burst arriving during PAYLOAD and running 2 cycles past the return to idle.
        stim = '{13'h0011, 13'h0022, 13'h0033};
        e0 = n_en;
        d0 = n_drop;
        drive_burst();
        repeat (5) @(posedge clk);
        #1;
        cnt  = 0;
        post = -1;
        while (cnt < 100) begin
            ren   = 1'b1;
            rdata = 13'(cnt + 13'h100);
            @(posedge clk);
            #1;
            cnt++;
            if (post < 0 && !busy) post = 0;
            else if (post >= 0) post++;
            if (post == 2) break;
        end
        ren = 1'b0;
        exp_drops += cnt;
        check("late_burst_bounded", 32'(cnt < 100), 32'd1);
        repeat (3) @(negedge clk);
        check("late_burst_drops", 32'(n_drop - d0), 32'(cnt));
        check("late_burst_no_frame", 32'(n_en - e0), 32'd7);
        stim = '{13'h0101, 13'h0202, 13'h0303, 13'h0404};
        e0 = n_en;
        drive_burst();
        wait_idle(60);
        check("clean_after_drop", 32'(n_en - e0), 32'd8);

        // Random bursts through the scoreboard.
        for (int b = 0; b < 100; b++) begin
            int n;
            n = $urandom_range(1, 200);
            stim.delete();
            for (int i = 0; i < n; i++) stim.push_back(13'($urandom));
            e0 = n_en;
            drive_burst();
            wait_idle(400);
            check("rand_burst_len", 32'(n_en - e0), 32'(4 + n));
        end

        // Reset at the second payload word aborts the frame.
        stim = '{13'h0aa1, 13'h0aa2, 13'h0aa3, 13'h0aa4};
        drive_burst();
        repeat (6) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_en", 32'(tx_en), 32'h0);
        check("abort_data", 32'(tx_data), 32'h0);
        check("abort_busy", 32'(busy), 32'h0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        stim = '{13'h0777, 13'h0888};
        e0 = n_en;
        drive_burst();
        wait_idle(60);
        check("post_reset_frame", 32'(n_en - e0), 32'd6);

        repeat (3) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("total_drops", 32'(n_drop), 32'(exp_drops));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
